// File: rtl/bit_serial_adder_ctrl.sv
// Bit-serial adder: one shared 1-bit full adder, LSB first, WIDTH cycles per add.
// Holds the sequencing FSM, operand/result shift registers, carry flop and bit counter.

// One-bit full adder built from primitive gates so the serial datapath stays tiny.
module structuralFullAdder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  wire p;
  wire g;
  wire t;

  xor u_x0 (p, a, b);
  xor u_x1 (sum, p, cin);
  and u_a0 (g, a, b);
  and u_a1 (t, p, cin);
  or  u_o0 (cout, g, t);

endmodule

// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for start; previous result held on the outputs
// S_RUN  | one operand bit pair added per cycle, LSB first
// S_DONE | result complete; done high for this single cycle
module bit_serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MSB  = CW'(WIDTH - 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             c_msb_q, c_msb_d;
  logic             carryout_q, carryout_d;
  logic             overflow_q, overflow_d;

  logic fa_sum;
  logic fa_cout;

  structuralFullAdder u_fa (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (c_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Next-state and datapath update; every register holds unless the state says otherwise.
  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    sum_d      = sum_q;
    cnt_d      = cnt_q;
    c_d        = c_q;
    c_msb_d    = c_msb_q;
    carryout_d = carryout_q;
    overflow_d = overflow_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_d     = cin;
          cnt_d   = '0;
          sum_d   = '0;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        sum_d  = {fa_sum, sum_q[WIDTH-1:1]};
        c_d    = fa_cout;
        if (cnt_q == CNT_MSB) begin
          c_msb_d = fa_cout;
        end
        if (cnt_q == CNT_LAST) begin
          // c_msb_q holds the carry into the MSB, fa_cout the carry out of it.
          carryout_d = fa_cout;
          overflow_d = c_msb_q ^ fa_cout;
          state_d    = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      sum_q      <= '0;
      cnt_q      <= '0;
      c_q        <= 1'b0;
      c_msb_q    <= 1'b0;
      carryout_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      sum_q      <= sum_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      c_msb_q    <= c_msb_d;
      carryout_q <= carryout_d;
      overflow_q <= overflow_d;
    end
  end

  // Handshake flags decode straight from the state register.
  always_comb begin
    ready = (state_q == S_IDLE) || (state_q == S_DONE);
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
  end

  assign sum      = sum_q;
  assign carryout = carryout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bit_serial_adder_ctrl.sv
// Bench for bit_serial_adder_ctrl at WIDTH 8, 2 and 32. Expected results are
// queued when an add is issued and compared when the matching done appears.
module tb_bit_serial_adder_ctrl;

  logic        clk;
  logic        reset;
  logic        start_v [3];
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        cin_in;

  logic [7:0]  sum8;
  logic [1:0]  sum2;
  logic [31:0] sum32;
  logic        ready_v [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic        co_v    [3];
  logic        ov_v    [3];
  logic [31:0] sum_v   [3];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  typedef struct {
    int          idx;
    int          cyc;
    logic [31:0] sum;
    logic        co;
    logic        ov;
  } exp_t;

  exp_t sb[$];

  bit_serial_adder_ctrl #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start_v[0]),
    .a(a_in[7:0]), .b(b_in[7:0]), .cin(cin_in),
    .ready(ready_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .sum(sum8), .carryout(co_v[0]), .overflow(ov_v[0])
  );

  bit_serial_adder_ctrl #(.WIDTH(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start_v[1]),
    .a(a_in[1:0]), .b(b_in[1:0]), .cin(cin_in),
    .ready(ready_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .sum(sum2), .carryout(co_v[1]), .overflow(ov_v[1])
  );

  bit_serial_adder_ctrl #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start_v[2]),
    .a(a_in), .b(b_in), .cin(cin_in),
    .ready(ready_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .sum(sum32), .carryout(co_v[2]), .overflow(ov_v[2])
  );

  assign sum_v[0] = {24'd0, sum8};
  assign sum_v[1] = {30'd0, sum2};
  assign sum_v[2] = sum32;

  initial begin
    clk = 1'b0;
    forever #100 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int width_of(input int idx);
    case (idx)
      0:       return 8;
      1:       return 2;
      default: return 32;
    endcase
  endfunction

  // Reference: plain wide addition, signed overflow from operand/result sign bits.
  function automatic exp_t model(input int idx, input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv, input int done_cyc);
    exp_t        e;
    int          w;
    logic [63:0] mask;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] f;
    w    = width_of(idx);
    mask = (64'd1 << w) - 64'd1;
    x    = {32'd0, av} & mask;
    y    = {32'd0, bv} & mask;
    f    = x + y + {63'd0, cv};
    e.idx = idx;
    e.cyc = done_cyc;
    e.sum = f[31:0] & mask[31:0];
    e.co  = f[w];
    e.ov  = (x[w-1] == y[w-1]) && (f[w-1] != x[w-1]);
    return e;
  endfunction

  // Scoreboard consumer: every done must match the oldest outstanding add.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (done_v[i] === 1'b1) begin
        if (sb.size() == 0) begin
          check_eq("spurious_done", 64'(done_v[i]), 64'd0);
        end else begin
          e = sb.pop_front();
          check_eq("done_dut", 64'(i), 64'(e.idx));
          check_eq("done_cycle", 64'(cyc), 64'(e.cyc));
          check_eq("sum", 64'(sum_v[i]), 64'(e.sum));
          check_eq("carryout", 64'(co_v[i]), 64'(e.co));
          check_eq("overflow", 64'(ov_v[i]), 64'(e.ov));
        end
      end
    end
  end

  // Called on a falling edge; start is sampled on the following rising edge.
  task automatic issue(input int idx, input logic [31:0] av, input logic [31:0] bv,
                       input logic cv, input bit hold);
    int guard;
    guard = 0;
    while (ready_v[idx] !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check_eq("ready_timeout", 64'(ready_v[idx]), 64'd1);
    a_in   = av;
    b_in   = bv;
    cin_in = cv;
    start_v[idx] = 1'b1;
    sb.push_back(model(idx, av, bv, cv, cyc + 1 + width_of(idx)));
    @(negedge clk);
    if (!hold) start_v[idx] = 1'b0;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb.size() != 0) begin
      check_eq("done_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    #(200 * 90000);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    a_in    = '0;
    b_in    = '0;
    cin_in  = 1'b0;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 64'(ready_v[0]), 64'd1);
    check_eq("rst_busy", 64'(busy_v[0]), 64'd0);
    check_eq("rst_done", 64'(done_v[0]), 64'd0);
    check_eq("rst_sum", 64'(sum_v[0]), 64'd0);
    check_eq("rst_carryout", 64'(co_v[0]), 64'd0);
    check_eq("rst_overflow", 64'(ov_v[0]), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed carry/overflow corners on WIDTH=8.
    issue(0, 32'h0F, 32'h01, 1'b0, 1'b0); wait_idle();
    issue(0, 32'hFF, 32'h01, 1'b0, 1'b0); wait_idle();
    issue(0, 32'h7F, 32'h01, 1'b0, 1'b0); wait_idle();
    issue(0, 32'h80, 32'h80, 1'b1, 1'b0); wait_idle();

    // Start pulse and operand change mid-add must be ignored.
    issue(0, 32'h01, 32'h02, 1'b0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      check_eq("ready_in_run", 64'(ready_v[0]), 64'd0);
      if (k == 3) begin
        a_in = 32'h55;
        start_v[0] = 1'b1;
      end else begin
        start_v[0] = 1'b0;
      end
      @(negedge clk);
    end
    wait_idle();

    // Reset in the 4th RUN cycle aborts the add without a done.
    issue(0, 32'h33, 32'h44, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    check_eq("abort_sum", 64'(sum_v[0]), 64'd0);
    check_eq("abort_ready", 64'(ready_v[0]), 64'd1);
    check_eq("abort_busy", 64'(busy_v[0]), 64'd0);
    check_eq("abort_carryout", 64'(co_v[0]), 64'd0);
    repeat (12) @(negedge clk);
    issue(0, 32'hA5, 32'h5A, 1'b1, 1'b0); wait_idle();

    // Start held across DONE: next add loads directly from DONE.
    issue(0, 32'h10, 32'h20, 1'b0, 1'b1);
    repeat (8) @(negedge clk);
    check_eq("b2b_done_first", 64'(done_v[0]), 64'd1);
    a_in   = 32'h01;
    b_in   = 32'h01;
    cin_in = 1'b0;
    sb.push_back(model(0, 32'h01, 32'h01, 1'b0, cyc + 1 + 8));
    @(negedge clk);
    start_v[0] = 1'b0;
    wait_idle();

    // Random and boundary operands on all three widths.
    for (int n = 0; n < 1000; n++) begin
      issue(0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      wait_idle();
    end
    issue(1, 32'h3, 32'h3, 1'b1, 1'b0); wait_idle();
    issue(1, 32'h1, 32'h1, 1'b0, 1'b0); wait_idle();
    for (int n = 0; n < 200; n++) begin
      issue(1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      wait_idle();
    end
    issue(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0); wait_idle();
    issue(2, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 1'b0); wait_idle();
    for (int n = 0; n < 100; n++) begin
      issue(2, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      wait_idle();
    end

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
